hs_pipe_chain: RTL

//   Parametrised valid/ready pipeline between one producer (master) and one consumer (slave).

---
 rtl/hs_pipe_chain.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/hs_pipe_chain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : hs_pipe_chain
//  Description : Valid/ready pipeline of DEPTH register slices of one kind
//                (forward, backward/skid or full two-entry buffer), with an
//                occupancy count of the words held in the chain.
//  Revision    : 1.0 - initial release
// ============================================================================
module hs_pipe_chain #(
    parameter int L     = 8,
    parameter int DEPTH = 2,
    parameter int MODE  = 2,
    // Derived sizing; not intended to be overridden
    parameter int CAP   = (MODE == 2) ? 2 * DEPTH : DEPTH,
    parameter int LW    = $clog2(CAP + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_f,
    input  logic [L-1:0]  data_f,
    output logic          ready_f,
    output logic          valid_b,
    output logic [L-1:0]  data_b,
    input  logic          ready_b,
    output logic [LW-1:0] level
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if ((MODE < 0) || (MODE > 2)) begin : g_bad_mode
        $error("hs_pipe_chain: MODE must be 0 (forward), 1 (backward) or 2 (full)");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("hs_pipe_chain: DEPTH must be at least 1");
    end

    // ------------------------------------------------------------------------
    // Inter-slice handshake nets: index i is the upstream side of slice i,
    // index i+1 its downstream side. Index 0 faces the producer, DEPTH the
    // consumer.
    // ------------------------------------------------------------------------
    logic          ch_vld [0:DEPTH];
    logic [L-1:0]  ch_dat [0:DEPTH];
    logic          ch_rdy [0:DEPTH];

    // run_q stays low during reset and rises on the first edge after release.
    // It holds ready_f low and masks valid_f until the chain is live, which
    // also keeps a combinational forward path from leaking valid_f to
    // valid_b while rst is high.
    logic run_q;

    // Leave reset one clock after rst deasserts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    assign ch_vld[0]     = valid_f & run_q;
    assign ch_dat[0]     = data_f;
    assign ready_f       = ch_rdy[0] & run_q;
    assign valid_b       = ch_vld[DEPTH];
    assign data_b        = ch_dat[DEPTH];
    assign ch_rdy[DEPTH] = ready_b;

    // ------------------------------------------------------------------------
    // Slice chain
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < DEPTH; i++) begin : g_slice
        if (MODE == 0) begin : g_fwd
            // Forward slice: valid/data registered, ready passes straight
            // through so the slice refills in the cycle it drains.
            logic         vld_q;
            logic [L-1:0] dat_q;

            assign ch_rdy[i]   = ~vld_q | ch_rdy[i+1];
            assign ch_vld[i+1] = vld_q;
            assign ch_dat[i+1] = dat_q;

            // Capture the upstream word whenever the slice may advance
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= 1'b0;
                    dat_q <= '0;
                end else if (ch_rdy[i]) begin
                    vld_q <= ch_vld[i];
                    dat_q <= ch_dat[i];
                end
            end
        end else if (MODE == 1) begin : g_bwd
            // Backward (skid) slice: ready registered, the word normally
            // passes through and is parked in the skid only when the
            // downstream side stalls in the cycle it was accepted.
            logic         sk_vld_q;
            logic [L-1:0] sk_dat_q;

            assign ch_rdy[i]   = ~sk_vld_q;
            assign ch_vld[i+1] = sk_vld_q | ch_vld[i];
            assign ch_dat[i+1] = sk_vld_q ? sk_dat_q : ch_dat[i];

            // Park an accepted-but-blocked word; release it once downstream takes it
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sk_vld_q <= 1'b0;
                    sk_dat_q <= '0;
                end else if (ch_vld[i] & ~sk_vld_q & ~ch_rdy[i+1]) begin
                    sk_vld_q <= 1'b1;
                    sk_dat_q <= ch_dat[i];
                end else if (sk_vld_q & ch_rdy[i+1]) begin
                    sk_vld_q <= 1'b0;
                end
            end
        end else if (MODE == 2) begin : g_full
            // Full slice: two-entry buffer, both valid and ready registered.
            // The second (tail) entry absorbs the word that arrives in the
            // cycle the downstream stalls, so throughput stays one per clk.
            localparam logic [1:0] S_EMPTY = 2'd0;
            localparam logic [1:0] S_HALF  = 2'd1;
            localparam logic [1:0] S_FULL  = 2'd2;

            logic [1:0]   state_q;
            logic [1:0]   state_d;
            logic [L-1:0] head_q;
            logic [L-1:0] tail_q;
            logic         up_rdy;
            logic         dn_vld;
            logic         in_x;
            logic         out_x;

            assign in_x  = ch_vld[i] & ch_rdy[i];
            assign out_x = ch_vld[i+1] & ch_rdy[i+1];

            // State register
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q <= S_EMPTY;
                end else begin
                    state_q <= state_d;
                end
            end

            // Next-state: fill level of the two-entry buffer
            always_comb begin
                state_d = state_q;
                case (state_q)
                    S_EMPTY: if (in_x)                state_d = S_HALF;
                    S_HALF:  if (in_x & ~out_x)       state_d = S_FULL;
                             else if (~in_x & out_x)  state_d = S_EMPTY;
                    S_FULL:  if (out_x)               state_d = S_HALF;
                    default:                          state_d = S_EMPTY;
                endcase
            end

            // Outputs decoded from the registered state only
            always_comb begin
                up_rdy = (state_q != S_FULL);
                dn_vld = (state_q != S_EMPTY);
            end

            assign ch_rdy[i]   = up_rdy;
            assign ch_vld[i+1] = dn_vld;
            assign ch_dat[i+1] = head_q;

            // Head/tail storage; head is always the oldest word held
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    head_q <= '0;
                    tail_q <= '0;
                end else begin
                    case (state_q)
                        S_EMPTY: if (in_x) head_q <= ch_dat[i];
                        S_HALF: begin
                            if (in_x & ~out_x)     tail_q <= ch_dat[i];
                            else if (in_x & out_x) head_q <= ch_dat[i];
                        end
                        S_FULL:  if (out_x) head_q <= tail_q;
                        default: ;
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Occupancy counter
    // ------------------------------------------------------------------------
    logic          in_xfer;
    logic          out_xfer;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;

    assign in_xfer  = valid_f & ready_f;
    assign out_xfer = valid_b & ready_b;

    // Net change of held words this cycle
    always_comb begin
        level_d = level_q;
        if (in_xfer & ~out_xfer) begin
            level_d = level_q + LW'(1);
        end else if (~in_xfer & out_xfer) begin
            level_d = level_q - LW'(1);
        end
    end

    // Occupancy register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule
`default_nettype wire
